// File: rtl/bp_cce_lite_responder.sv
//==============================================================================
// Module      : bp_cce_lite_responder
// Description : Minimal single-LCE coherence responder. Accepts one LCE
//               request at a time, issues one memory command for it, then
//               streams the fill (or single uncached beat) back as LCE
//               commands. After a block fill it waits for the LCE coh_ack
//               before accepting the next request.
//
// Ports       : clk_i / reset_i        clock, asynchronous active-high reset
//               cce_id_i               this CCE's ID (cmd header src_id)
//               lce_req_*              LCE request channel (ready&valid)
//               lce_cmd_*              LCE command channel (ready&valid)
//               lce_resp_*             LCE response channel (ready&valid)
//               mem_cmd_*              memory command channel (ready&valid)
//               mem_resp_*             memory read-beat channel (ready&valid)
//               error_o                sticky protocol error flag
//
// Header layouts (LSB first):
//   request  : msg_type[4] addr[PADDR] size[3] src_id[LCE] non_excl[1] lru_way[WAY]
//   command  : msg_type[4] addr[PADDR] size[3] dst_id[LCE] src_id[CCE] way_id[WAY] state[3]
//   response : msg_type[4] addr[PADDR] size[3] src_id[LCE]
//
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module bp_cce_lite_responder #(
    parameter int PADDR_WIDTH  = 40,
    parameter int LCE_ID_WIDTH = 8,
    parameter int CCE_ID_WIDTH = 8,
    parameter int LCE_ASSOC    = 8,
    parameter int BLOCK_WIDTH  = 512,
    parameter int FILL_WIDTH   = 64,
    localparam int WAY_ID_WIDTH          = (LCE_ASSOC > 1) ? $clog2(LCE_ASSOC) : 1,
    localparam int LCE_REQ_HEADER_WIDTH  = 4 + PADDR_WIDTH + 3 + LCE_ID_WIDTH + 1 + WAY_ID_WIDTH,
    localparam int LCE_CMD_HEADER_WIDTH  = 4 + PADDR_WIDTH + 3 + LCE_ID_WIDTH + CCE_ID_WIDTH
                                           + WAY_ID_WIDTH + 3,
    localparam int LCE_RESP_HEADER_WIDTH = 4 + PADDR_WIDTH + 3 + LCE_ID_WIDTH
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [CCE_ID_WIDTH-1:0]          cce_id_i,

    input  logic [LCE_REQ_HEADER_WIDTH-1:0]  lce_req_header_i,
    input  logic [FILL_WIDTH-1:0]            lce_req_data_i,
    input  logic                             lce_req_v_i,
    output logic                             lce_req_ready_and_o,

    output logic [LCE_CMD_HEADER_WIDTH-1:0]  lce_cmd_header_o,
    output logic [FILL_WIDTH-1:0]            lce_cmd_data_o,
    output logic                             lce_cmd_v_o,
    input  logic                             lce_cmd_ready_and_i,

    input  logic [LCE_RESP_HEADER_WIDTH-1:0] lce_resp_header_i,
    input  logic                             lce_resp_v_i,
    output logic                             lce_resp_ready_and_o,

    output logic [PADDR_WIDTH-1:0]           mem_cmd_addr_o,
    output logic                             mem_cmd_w_o,
    output logic [2:0]                       mem_cmd_size_o,
    output logic [FILL_WIDTH-1:0]            mem_cmd_data_o,
    output logic                             mem_cmd_v_o,
    input  logic                             mem_cmd_ready_and_i,

    input  logic [FILL_WIDTH-1:0]            mem_resp_data_i,
    input  logic                             mem_resp_v_i,
    output logic                             mem_resp_ready_and_o,

    output logic                             error_o
);

    // Header field positions (shared prefix of all three header types)
    localparam int c_addr_lsb = 4;
    localparam int c_size_lsb = c_addr_lsb + PADDR_WIDTH;
    localparam int c_pay_lsb  = c_size_lsb + 3;

    // Message / coherence-state encodings
    localparam logic [3:0] c_req_rd_miss   = 4'd0;
    localparam logic [3:0] c_req_wr_miss   = 4'd1;
    localparam logic [3:0] c_req_uc_rd     = 4'd2;
    localparam logic [3:0] c_req_uc_wr     = 4'd3;
    localparam logic [3:0] c_cmd_data      = 4'd4;
    localparam logic [3:0] c_cmd_uc_data   = 4'd11;
    localparam logic [3:0] c_cmd_uc_st_done = 4'd12;
    localparam logic [3:0] c_resp_coh_ack  = 4'd2;
    localparam logic [2:0] c_coh_i         = 3'd0;
    localparam logic [2:0] c_coh_s         = 3'd1;
    localparam logic [2:0] c_coh_e         = 3'd2;

    // Fill geometry
    localparam int           c_beats      = BLOCK_WIDTH / FILL_WIDTH;
    localparam int           c_cnt_w      = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(c_beats - 1);
    localparam int           c_off        = $clog2(FILL_WIDTH / 8);
    localparam logic [2:0]   c_block_size = 3'($clog2(BLOCK_WIDTH / 8));

    typedef enum logic [2:0] {
        e_ready    = 3'd0,
        e_mem_cmd  = 3'd1,
        e_fill     = 3'd2,
        e_uc_resp  = 3'd3,
        e_wait_ack = 3'd4
    } state_e;

    state_e                          r_state;
    state_e                          w_next_state;
    logic [LCE_REQ_HEADER_WIDTH-1:0] r_req_hdr;
    logic [FILL_WIDTH-1:0]           r_req_data;
    logic [c_cnt_w-1:0]              r_cnt;
    logic                            r_error;

    logic                            w_latch;
    logic                            w_cnt_inc;
    logic                            w_cnt_clr;
    logic                            w_set_err;

    // Latched request fields
    logic [3:0]                      w_req_msg;
    logic [PADDR_WIDTH-1:0]          w_req_addr;
    logic [2:0]                      w_req_size;
    logic [LCE_ID_WIDTH-1:0]         w_req_src;
    logic                            w_req_nonex;
    logic [WAY_ID_WIDTH-1:0]         w_req_way;
    logic                            w_is_miss;
    logic                            w_is_uc_wr;

    // Incoming request / response decode
    logic [3:0]                      w_in_msg;
    logic                            w_in_ok;
    logic [3:0]                      w_resp_msg;
    logic [LCE_ID_WIDTH-1:0]         w_resp_src;
    logic                            w_resp_unused;

    // Command header fields
    logic [3:0]                      w_cmd_msg;
    logic [PADDR_WIDTH-1:0]          w_cmd_addr;
    logic [2:0]                      w_cmd_size;
    logic [2:0]                      w_cmd_coh;

    assign w_req_msg   = r_req_hdr[3:0];
    assign w_req_addr  = r_req_hdr[c_addr_lsb +: PADDR_WIDTH];
    assign w_req_size  = r_req_hdr[c_size_lsb +: 3];
    assign w_req_src   = r_req_hdr[c_pay_lsb +: LCE_ID_WIDTH];
    assign w_req_nonex = r_req_hdr[c_pay_lsb + LCE_ID_WIDTH];
    assign w_req_way   = r_req_hdr[c_pay_lsb + LCE_ID_WIDTH + 1 +: WAY_ID_WIDTH];
    assign w_is_miss   = (w_req_msg == c_req_rd_miss) || (w_req_msg == c_req_wr_miss);
    assign w_is_uc_wr  = (w_req_msg == c_req_uc_wr);

    assign w_in_msg = lce_req_header_i[3:0];
    assign w_in_ok  = (w_in_msg == c_req_rd_miss) || (w_in_msg == c_req_wr_miss)
                   || (w_in_msg == c_req_uc_rd)   || (w_in_msg == c_req_uc_wr);

    assign w_resp_msg    = lce_resp_header_i[3:0];
    assign w_resp_src    = lce_resp_header_i[c_pay_lsb +: LCE_ID_WIDTH];
    // Response addr/size carry no information for a coh_ack
    assign w_resp_unused = ^lce_resp_header_i[c_pay_lsb-1:c_addr_lsb];

    // Misses fetch starting at the critical beat; uncached ops use the request as-is
    assign w_cmd_addr = w_is_miss ? {w_req_addr[PADDR_WIDTH-1:c_off], {c_off{1'b0}}} : w_req_addr;
    assign w_cmd_size = w_is_miss ? c_block_size : w_req_size;
    assign w_cmd_msg  = w_is_miss  ? c_cmd_data
                      : w_is_uc_wr ? c_cmd_uc_st_done
                      :              c_cmd_uc_data;
    // Exclusive unless a read miss asked for non-exclusive
    assign w_cmd_coh  = !w_is_miss ? c_coh_i
                      : ((w_req_msg == c_req_wr_miss) || !w_req_nonex) ? c_coh_e
                      : c_coh_s;

    assign lce_cmd_header_o = {w_cmd_coh, w_req_way, cce_id_i, w_req_src,
                               w_cmd_size, w_cmd_addr, w_cmd_msg};

    assign mem_cmd_addr_o = w_cmd_addr;
    assign mem_cmd_size_o = w_cmd_size;
    assign mem_cmd_w_o    = w_is_uc_wr;
    assign mem_cmd_data_o = w_is_uc_wr ? r_req_data : '0;

    assign error_o = r_error;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= e_ready;
            r_req_hdr  <= '0;
            r_req_data <= '0;
            r_cnt      <= '0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_latch) begin
                r_req_hdr  <= lce_req_header_i;
                r_req_data <= lce_req_data_i;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            if (w_set_err) begin
                r_error <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state         = r_state;
        lce_req_ready_and_o  = 1'b0;
        lce_cmd_v_o          = 1'b0;
        lce_cmd_data_o       = '0;
        lce_resp_ready_and_o = 1'b0;
        mem_cmd_v_o          = 1'b0;
        mem_resp_ready_and_o = 1'b0;
        w_latch              = 1'b0;
        w_cnt_inc            = 1'b0;
        w_cnt_clr            = 1'b0;
        w_set_err            = 1'b0;

        case (r_state)
            e_ready: begin
                // Hold ready low while reset is asserted so no handshake is
                // advertised during an asynchronous reset
                lce_req_ready_and_o = ~reset_i;
                if (lce_req_v_i && !reset_i) begin
                    if (w_in_ok) begin
                        w_latch      = 1'b1;
                        w_next_state = e_mem_cmd;
                    end else begin
                        w_set_err = 1'b1;
                    end
                end
            end

            e_mem_cmd: begin
                mem_cmd_v_o = 1'b1;
                if (mem_cmd_ready_and_i) begin
                    w_cnt_clr    = 1'b1;
                    w_next_state = w_is_uc_wr ? e_uc_resp : e_fill;
                end
            end

            e_fill: begin
                // Zero-bubble pass-through: memory beats are never buffered
                lce_cmd_v_o          = mem_resp_v_i;
                mem_resp_ready_and_o = lce_cmd_ready_and_i;
                lce_cmd_data_o       = mem_resp_data_i;
                if (mem_resp_v_i && lce_cmd_ready_and_i) begin
                    if (!w_is_miss) begin
                        w_next_state = e_ready;
                    end else if (r_cnt == c_last_beat) begin
                        w_cnt_clr    = 1'b1;
                        w_next_state = e_wait_ack;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end

            e_uc_resp: begin
                lce_cmd_v_o = 1'b1;
                if (lce_cmd_ready_and_i) begin
                    w_next_state = e_ready;
                end
            end

            e_wait_ack: begin
                lce_resp_ready_and_o = 1'b1;
                if (lce_resp_v_i) begin
                    if ((w_resp_msg == c_resp_coh_ack) && (w_resp_src == w_req_src)) begin
                        w_next_state = e_ready;
                    end else begin
                        w_set_err = 1'b1;
                    end
                end
            end

            default: begin
                w_next_state = e_ready;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_bp_cce_lite_responder.sv
//==============================================================================
// Module      : tb_bp_cce_lite_responder
// Description : Self-checking bench for bp_cce_lite_responder. A table of
//               request records is driven end to end, followed by directed
//               sequences for backpressure, bad acks, mid-fill reset and
//               unsupported request types.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bp_cce_lite_responder;

    localparam int PW   = 40;
    localparam int FW   = 64;
    localparam int REQW = 59;
    localparam int CMDW = 69;
    localparam int RSPW = 55;

    localparam logic [3:0] RD_MISS = 4'd0, WR_MISS = 4'd1, UC_RD = 4'd2, UC_WR = 4'd3, UC_AMO = 4'd4;
    localparam logic [3:0] CMD_DATA = 4'd4, CMD_UC_DATA = 4'd11, CMD_UC_ST_DONE = 4'd12;
    localparam logic [3:0] COH_ACK = 4'd2;
    localparam logic [7:0] SRC = 8'h05;
    localparam logic [7:0] CCE = 8'h3C;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [REQW-1:0] rq_hdr = '0;
    logic [FW-1:0]   rq_data = '0;
    logic            rq_v = 1'b0;
    logic            rq_rdy;
    logic [CMDW-1:0] cmd_hdr;
    logic [FW-1:0]   cmd_data;
    logic            cmd_v;
    logic            cmd_rdy = 1'b0;
    logic [RSPW-1:0] rs_hdr = '0;
    logic            rs_v = 1'b0;
    logic            rs_rdy;
    logic [PW-1:0]   mc_addr;
    logic            mc_w;
    logic [2:0]      mc_size;
    logic [FW-1:0]   mc_data;
    logic            mc_v;
    logic            mc_rdy = 1'b0;
    logic [FW-1:0]   mr_data = '0;
    logic            mr_v = 1'b0;
    logic            mr_rdy;
    logic            err;

    int n_cmp = 0;
    int n_err = 0;

    bp_cce_lite_responder dut (
        .clk_i                (clk),
        .reset_i              (rst),
        .cce_id_i             (CCE),
        .lce_req_header_i     (rq_hdr),
        .lce_req_data_i       (rq_data),
        .lce_req_v_i          (rq_v),
        .lce_req_ready_and_o  (rq_rdy),
        .lce_cmd_header_o     (cmd_hdr),
        .lce_cmd_data_o       (cmd_data),
        .lce_cmd_v_o          (cmd_v),
        .lce_cmd_ready_and_i  (cmd_rdy),
        .lce_resp_header_i    (rs_hdr),
        .lce_resp_v_i         (rs_v),
        .lce_resp_ready_and_o (rs_rdy),
        .mem_cmd_addr_o       (mc_addr),
        .mem_cmd_w_o          (mc_w),
        .mem_cmd_size_o       (mc_size),
        .mem_cmd_data_o       (mc_data),
        .mem_cmd_v_o          (mc_v),
        .mem_cmd_ready_and_i  (mc_rdy),
        .mem_resp_data_i      (mr_data),
        .mem_resp_v_i         (mr_v),
        .mem_resp_ready_and_o (mr_rdy),
        .error_o              (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  msg;
        logic [39:0] addr;
        logic [2:0]  size;
        logic [63:0] data;
        logic        nonex;
        logic [2:0]  way;
        logic [39:0] m_addr;
        logic [2:0]  m_size;
        logic        m_w;
        logic [63:0] m_data;
        logic [3:0]  c_msg;
        logic [39:0] c_addr;
        logic [2:0]  c_size;
        logic [2:0]  c_state;
        int          beats;
    } vec_t;

    vec_t tbl [5];

    function automatic logic [REQW-1:0] mk_req(input logic [3:0] msg, input logic [39:0] addr,
                                               input logic [2:0] size, input logic [7:0] src,
                                               input logic nonex, input logic [2:0] way);
        return {way, nonex, src, size, addr, msg};
    endfunction

    function automatic logic [CMDW-1:0] mk_cmd(input logic [3:0] msg, input logic [39:0] addr,
                                               input logic [2:0] size, input logic [2:0] way,
                                               input logic [2:0] state);
        return {state, way, CCE, SRC, size, addr, msg};
    endfunction

    function automatic logic [RSPW-1:0] mk_resp(input logic [3:0] msg, input logic [7:0] src);
        return {src, 3'd0, 40'd0, msg};
    endfunction

    function automatic logic [63:0] beat_data(input logic [31:0] base, input int i);
        return {base, 32'(i)};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [REQW-1:0] hdr, input logic [63:0] data);
        int n = 0;
        rq_hdr  = hdr;
        rq_data = data;
        rq_v    = 1'b1;
        #1;
        while (!rq_rdy && n < 20) begin
            tick();
            n++;
        end
        chk("req_ready", rq_rdy, 1'b1);
        tick();
        rq_v = 1'b0;
    endtask

    task automatic send_ack(input logic [7:0] src);
        rs_hdr = mk_resp(COH_ACK, src);
        rs_v   = 1'b1;
        #1;
        chk("ack_resp_ready", rs_rdy, 1'b1);
        tick();
        rs_v = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req_ready", rq_rdy, 1'b0);
        chk("rst_cmd_v", cmd_v, 1'b0);
        chk("rst_mem_cmd_v", mc_v, 1'b0);
        chk("rst_error", err, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", rq_rdy, 1'b1);
    endtask

    // Streams beats into the DUT, checking each forwarded command beat.
    // stall_at/stall_n hold command ready low for stall_n cycles at that beat;
    // abort_at asserts reset mid-cycle while that beat is being presented.
    task automatic do_fill(input logic [CMDW-1:0] exp_hdr, input int beats, input logic [31:0] base,
                           input int stall_at, input int stall_n, input int abort_at);
        int got = 0;
        int cyc = 0;
        int stall_left = stall_n;
        mr_v = 1'b1;
        while (got < beats && cyc < 200) begin
            mr_data = beat_data(base, got);
            cmd_rdy = !(got == stall_at && stall_left > 0);
            #1;
            if (got == abort_at) begin
                chk("abort_cmd_v_before", cmd_v, 1'b1);
                #2 rst = 1'b1;
                #1;
                chk("abort_cmd_v", cmd_v, 1'b0);
                chk("abort_mem_resp_ready", mr_rdy, 1'b0);
                chk("abort_req_ready", rq_rdy, 1'b0);
                chk("abort_mem_cmd_v", mc_v, 1'b0);
                tick();
                mr_v    = 1'b0;
                cmd_rdy = 1'b0;
                rst     = 1'b0;
                #1;
                chk("abort_ready_after", rq_rdy, 1'b1);
                return;
            end
            chk("fill_mem_resp_ready", mr_rdy, cmd_rdy);
            chk("fill_cmd_v", cmd_v, 1'b1);
            if (!cmd_rdy) begin
                stall_left--;
            end else if (cmd_v) begin
                chk("fill_cmd_hdr", cmd_hdr, exp_hdr);
                chk("fill_cmd_data", cmd_data, beat_data(base, got));
                got++;
            end
            tick();
            cyc++;
        end
        // Keep offering a beat: a correct DUT must no longer take it
        mr_data = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        chk("fill_done_cmd_v", cmd_v, 1'b0);
        chk("fill_beat_count", got, beats);
        mr_v    = 1'b0;
        cmd_rdy = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input logic [31:0] base, input int stall_at,
                           input int stall_n, input int abort_at, input logic do_ack);
        int n = 0;
        send_req(mk_req(v.msg, v.addr, v.size, SRC, v.nonex, v.way), v.data);
        while (!mc_v && n < 20) begin
            tick();
            n++;
        end
        chk("mem_cmd_v", mc_v, 1'b1);
        chk("mem_cmd_addr", mc_addr, v.m_addr);
        chk("mem_cmd_size", mc_size, v.m_size);
        chk("mem_cmd_w", mc_w, v.m_w);
        chk("mem_cmd_data", mc_data, v.m_data);
        mc_rdy = 1'b1;
        tick();
        mc_rdy = 1'b0;
        if (v.c_msg == CMD_UC_ST_DONE) begin
            n = 0;
            while (!cmd_v && n < 20) begin
                tick();
                n++;
            end
            chk("st_done_v", cmd_v, 1'b1);
            chk("st_done_hdr", cmd_hdr, mk_cmd(v.c_msg, v.c_addr, v.c_size, v.way, v.c_state));
            chk("st_done_data", cmd_data, 64'd0);
            cmd_rdy = 1'b1;
            tick();
            cmd_rdy = 1'b0;
            chk("st_done_next_ready", rq_rdy, 1'b1);
            chk("st_done_no_ack_wait", rs_rdy, 1'b0);
        end else begin
            do_fill(mk_cmd(v.c_msg, v.c_addr, v.c_size, v.way, v.c_state), v.beats, base,
                    stall_at, stall_n, abort_at);
            if (abort_at >= 0) return;
            if (v.beats == 1) begin
                chk("uc_rd_next_ready", rq_rdy, 1'b1);
            end else begin
                chk("wait_ack_resp_ready", rs_rdy, 1'b1);
                chk("wait_ack_req_ready", rq_rdy, 1'b0);
                if (do_ack) begin
                    send_ack(SRC);
                    chk("ack_to_ready", rq_rdy, 1'b1);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          msg      addr           sz    data                nx    way   m_addr         m_sz  w     m_data              c_msg           c_addr         c_sz  st    beats
        tbl[0] = '{RD_MISS, 40'h8000_0048, 3'd6, 64'd0,             1'b0, 3'd3, 40'h8000_0048, 3'd6, 1'b0, 64'd0,             CMD_DATA,       40'h8000_0048, 3'd6, 3'd2, 8};
        tbl[1] = '{RD_MISS, 40'h8000_1237, 3'd3, 64'd0,             1'b1, 3'd5, 40'h8000_1230, 3'd6, 1'b0, 64'd0,             CMD_DATA,       40'h8000_1230, 3'd6, 3'd1, 8};
        tbl[2] = '{WR_MISS, 40'h4000_00FC, 3'd2, 64'd0,             1'b1, 3'd0, 40'h4000_00F8, 3'd6, 1'b0, 64'd0,             CMD_DATA,       40'h4000_00F8, 3'd6, 3'd2, 8};
        tbl[3] = '{UC_WR,   40'h10,        3'd3, 64'hDEAD_BEEF,     1'b0, 3'd0, 40'h10,        3'd3, 1'b1, 64'hDEAD_BEEF,     CMD_UC_ST_DONE, 40'h10,        3'd3, 3'd0, 1};
        tbl[4] = '{UC_RD,   40'h20,        3'd2, 64'd0,             1'b0, 3'd0, 40'h20,        3'd2, 1'b0, 64'd0,             CMD_UC_DATA,    40'h20,        3'd2, 3'd0, 1};

        #3;
        chk("reset_req_ready", rq_rdy, 1'b0);
        chk("reset_cmd_v", cmd_v, 1'b0);
        chk("reset_resp_ready", rs_rdy, 1'b0);
        chk("reset_mem_cmd_v", mc_v, 1'b0);
        chk("reset_mem_resp_ready", mr_rdy, 1'b0);
        chk("reset_error", err, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("idle_req_ready", rq_rdy, 1'b1);
        chk("idle_mem_cmd_v", mc_v, 1'b0);

        for (int i = 0; i < 5; i++) begin
            run_vec(tbl[i], 32'hC0DE_0000 + 32'(i), -1, 0, -1, 1'b1);
        end
        chk("table_no_error", err, 1'b0);

        // Backpressure: command ready low for 3 cycles while beat 4 is offered
        run_vec(tbl[0], 32'h5A11_0004, 4, 3, -1, 1'b1);

        // Reset while beat 5 is on the bus, then a fresh miss completes
        run_vec(tbl[0], 32'hAB00_0005, -1, 0, 5, 1'b0);
        chk("abort_error", err, 1'b0);
        run_vec(tbl[1], 32'hF0E5_0001, -1, 0, -1, 1'b1);

        // Wrong-source ack is consumed, flags an error and keeps waiting
        run_vec(tbl[0], 32'h0ACC_0000, -1, 0, -1, 1'b0);
        send_ack(8'h06);
        chk("bad_ack_error", err, 1'b1);
        chk("bad_ack_still_waiting", rs_rdy, 1'b1);
        chk("bad_ack_req_ready", rq_rdy, 1'b0);
        send_ack(SRC);
        chk("good_ack_ready", rq_rdy, 1'b1);
        chk("error_sticky", err, 1'b1);

        // Only reset clears the error; an unsupported request sets it again
        do_reset();
        send_req(mk_req(UC_AMO, 40'h100, 3'd3, SRC, 1'b0, 3'd0), 64'h1);
        chk("bad_req_error", err, 1'b1);
        chk("bad_req_stays_ready", rq_rdy, 1'b1);
        chk("bad_req_no_mem_cmd", mc_v, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bp_cce_lite_responder.md
Name: bp_cce_lite_responder

Overview:
- Minimal single-LCE coherence responder. It is the CCE-side counterpart that consumes LCE requests and answers with LCE commands.
- Targets configurations with one cache per CCE, e.g. unit test benches and accelerator tiles. Each miss is serviced by fetching the block from a streaming memory port and returning it as a data command. The responder then waits for the LCE's coherence ack before accepting the next request.
- Uncached loads and stores are serviced with a single beat.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies paddr_width_p, lce_id_width_p, cce_id_width_p, did_width_p, lce_assoc_p and the BedRock header widths.
- block_width_p, 512, cache block bits.
- fill_width_p, 64, bits per data beat on the command and memory-response channels. Must divide block_width_p and be ≥64.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- cce_id_i  in  cce_id_width_p  this CCE's ID; placed in cmd header src_id.
- lce_req_header_i  in  lce_req_header_width_lp  BedRock LCE request header.
- lce_req_data_i  in  fill_width_p  store data; single beat only.
- lce_req_v_i  in  1  request valid.
- lce_req_ready_and_o  out  1  request ready.
- lce_cmd_header_o  out  lce_cmd_header_width_lp  LCE command header.
- lce_cmd_data_o  out  fill_width_p  command data beat.
- lce_cmd_v_o  out  1  command valid.
- lce_cmd_ready_and_i  in  1  command ready.
- lce_resp_header_i  in  lce_resp_header_width_lp  LCE response header.
- lce_resp_v_i  in  1  response valid.
- lce_resp_ready_and_o  out  1  response ready.
- mem_cmd_addr_o  out  paddr_width_p  memory address; critical-beat aligned.
- mem_cmd_w_o  out  1  1 = write.
- mem_cmd_size_o  out  3  log2 bytes.
- mem_cmd_data_o  out  fill_width_p  write data.
- mem_cmd_v_o  out  1  memory command valid.
- mem_cmd_ready_and_i  in  1  memory command ready.
- mem_resp_data_i  in  fill_width_p  read beat; wrap order starting at the critical beat.
- mem_resp_v_i  in  1  read beat valid.
- mem_resp_ready_and_o  out  1  read beat ready.
- error_o  out  1  sticky protocol error flag.

Behaviour:
- Reset (asynchronous): state e_ready, error_o=0, all v_o/ready_and_o=0, beat counter=0, request registers=0.
- All channels are ready&valid; a transfer occurs only in a cycle where both are high.
- States: e_ready, e_mem_cmd, e_fill, e_uc_resp, e_wait_ack.

e_ready:
- lce_req_ready_and_o=1; all other v/ready outputs are 0.
- On handshake, latch header and data, then go to e_mem_cmd.
- Handled msg_types: e_bedrock_req_rd_miss, e_bedrock_req_wr_miss, e_bedrock_req_uc_rd, e_bedrock_req_uc_wr.
- Any other msg_type: set error_o, drop the request, stay in e_ready.

e_mem_cmd:
- mem_cmd_v_o=1.
- Miss: addr = request addr aligned down to fill_width_p/8 bytes, size = log2(block_width_p/8), w=0.
- Uncached: addr and size come from the request; w=1 for uc_wr, with data = latched data.
- On handshake: miss goes to e_fill with beat counter=0; uc_rd goes to e_fill; uc_wr goes to e_uc_resp.

e_fill (pass-through, zero bubble):
- lce_cmd_v_o = mem_resp_v_i.
- mem_resp_ready_and_o = lce_cmd_ready_and_i.
- lce_cmd_data_o = mem_resp_data_i.
- Miss header:
  - msg_type = e_bedrock_cmd_data.
  - addr = critical-beat address.
  - size = block size.
  - dst_id = request src_id.
  - way_id = request payload lru_way_id.
  - state = e_COH_E for wr_miss or for rd_miss with non_exclusive=0; otherwise e_COH_S.
- Header is held constant across all beats.
- Counter increments on each beat handshake.
- After beat (block_width_p/fill_width_p)-1 transfers, clear the counter and go to e_wait_ack. This is 8 beats at default parameters.
- uc_rd: header msg_type = e_bedrock_cmd_uc_data, with request size and addr. After 1 beat, go to e_ready.

e_uc_resp:
- lce_cmd_v_o=1, msg_type = e_bedrock_cmd_uc_st_done, data=0. After handshake, go to e_ready.

e_wait_ack:
- lce_resp_ready_and_o=1.
- A handshake with msg_type e_bedrock_resp_coh_ack and src_id equal to the latched LCE goes to e_ready.
- Any other response is accepted, sets error_o, and the state is unchanged.

Outside e_wait_ack:
- lce_resp_ready_and_o=0.

General rules:
- Ordering: at most one request is in flight, so requests are strictly serialized.
- Memory beats are never buffered; backpressure on the command channel stalls the memory response channel in the same cycle.
- Reset mid-transaction aborts immediately; partial fills are not resumed.
- error_o is cleared only by reset.

Test Plan:
- rd_miss addr 0x8000_0048, non_exclusive=0, lru_way=3 → one mem read of addr 0x8000_0048 with size 6. Then 8 cmd beats forwarding the mem data, with header state E, way 3, addr 0x8000_0048. Then coh_ack returns the block to ready.
- Hold lce_cmd_ready_and_i=0 for 3 cycles during beat 4 of a fill → mem_resp_ready_and_o=0 in exactly those cycles; no beat is lost or duplicated; beat count stays 8.
- uc_wr addr 0x10, size 3, data 0xDEAD_BEEF → mem write with the same fields, then one uc_st_done cmd to the requester; no ack is expected.
- uc_rd addr 0x20, size 2 → one uc_data beat equal to the mem beat; the next request is accepted on the following cycle.
- In e_wait_ack, send a coh_ack from a wrong src_id → error_o=1 and the block stays waiting. A correct ack then returns it to ready.
- Assert reset during beat 5 → all valids drop asynchronously and state is e_ready. A fresh rd_miss then completes normally.
